// File: rtl/filt_pkg.sv
// Shared filter-path constants: sample width, default delay-line depth and a clog2 helper.
package filt_pkg;

    localparam int SAMPLE_W   = 25;
    localparam int FILT_DEPTH = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tap_delay_line_if.sv
// Signal bundle between a tap_delay_line and its client (FIR tap multipliers, readback).
// The sum signal exists only when TAP_DELAY_LINE_SUM_EN is defined.
interface tap_delay_line_if
    import filt_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = FILT_DEPTH,
    parameter int IDX_W = clog2(FILT_DEPTH)
) ();

    logic                      clr;
    logic                      shift_en;
    logic signed [WIDTH-1:0]   din;
    logic [DEPTH*WIDTH-1:0]    taps;
    logic signed [WIDTH-1:0]   dout;
    logic [IDX_W:0]            fill_cnt;
    logic                      full;
    logic [IDX_W-1:0]          rd_idx;
    logic signed [WIDTH-1:0]   rd_data;
`ifdef TAP_DELAY_LINE_SUM_EN
    logic signed [WIDTH+IDX_W:0] sum;

    modport master (
        output clr, shift_en, din, rd_idx,
        input  taps, dout, fill_cnt, full, rd_data, sum
    );

    modport slave (
        input  clr, shift_en, din, rd_idx,
        output taps, dout, fill_cnt, full, rd_data, sum
    );
`else
    modport master (
        output clr, shift_en, din, rd_idx,
        input  taps, dout, fill_cnt, full, rd_data
    );

    modport slave (
        input  clr, shift_en, din, rd_idx,
        output taps, dout, fill_cnt, full, rd_data
    );
`endif

endinterface

// File: rtl/dl_stage.sv
// One delay-line register: async reset, synchronous clear, load on enable.
module dl_stage
    import filt_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] d,
    output logic signed [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/tap_delay_line.sv
// DEPTH-stage sample delay line with fill tracking and registered tap readback.
// Defining TAP_DELAY_LINE_SUM_EN adds a running sum of all stages for moving-average use.
module tap_delay_line
    import filt_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = FILT_DEPTH,
    parameter int IDX_W = clog2(FILT_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    tap_delay_line_if.slave bus
);

    localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(DEPTH);
    localparam int             SUM_W   = WIDTH + IDX_W + 1;

    logic signed [WIDTH-1:0] stage [DEPTH];
    logic signed [WIDTH-1:0] rd_sel;
    logic signed [WIDTH-1:0] rd_data_p1;
    logic [IDX_W:0]          fill_cnt;
    logic                    full;

    function automatic logic [IDX_W:0] fill_sat_inc(input logic [IDX_W:0] cnt);
        return (cnt >= DEPTH_C) ? DEPTH_C : cnt + 1'b1;
    endfunction

    // Stage 0 takes the new sample; every other stage takes its predecessor.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            dl_stage #(.WIDTH(WIDTH)) u_stage (
                .clk (clk),
                .rst (rst),
                .clr (bus.clr),
                .en  (bus.shift_en),
                .d   (bus.din),
                .q   (stage[k])
            );
        end else begin : g_body
            dl_stage #(.WIDTH(WIDTH)) u_stage (
                .clk (clk),
                .rst (rst),
                .clr (bus.clr),
                .en  (bus.shift_en),
                .d   (stage[k-1]),
                .q   (stage[k])
            );
        end
        assign bus.taps[k*WIDTH +: WIDTH] = stage[k];
    end

    assign bus.dout = stage[DEPTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt <= '0;
            full     <= 1'b0;
        end else if (bus.clr) begin
            fill_cnt <= '0;
            full     <= 1'b0;
        end else if (bus.shift_en) begin
            fill_cnt <= fill_sat_inc(fill_cnt);
            full     <= (fill_sat_inc(fill_cnt) == DEPTH_C);
        end
    end

    assign bus.fill_cnt = fill_cnt;
    assign bus.full     = full;

    // Out-of-range indices fall through to the zero default.
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (int'(bus.rd_idx) == k) begin
                rd_sel = stage[k];
            end
        end
    end

    // Readback register: samples pre-edge stage values, one cycle behind rd_idx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_p1 <= '0;
        end else if (bus.clr) begin
            rd_data_p1 <= '0;
        end else begin
            rd_data_p1 <= rd_sel;
        end
    end

    assign bus.rd_data = rd_data_p1;

`ifdef TAP_DELAY_LINE_SUM_EN
    logic signed [SUM_W-1:0] sum_p1;

    function automatic logic signed [SUM_W-1:0] sext(input logic signed [WIDTH-1:0] x);
        return {{(SUM_W - WIDTH){x[WIDTH-1]}}, x};
    endfunction

    // Unfilled stages are zero, so subtracting the evicted stage is always exact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_p1 <= '0;
        end else if (bus.clr) begin
            sum_p1 <= '0;
        end else if (bus.shift_en) begin
            sum_p1 <= sum_p1 + sext(bus.din) - sext(stage[DEPTH-1]);
        end
    end

    assign bus.sum = sum_p1;
`endif

endmodule

// File: tb/tb_tap_delay_line.sv
// Directed bench for tap_delay_line (DEPTH=8, WIDTH=25); sum checks when TAP_DELAY_LINE_SUM_EN is defined.
module tb_tap_delay_line;

    localparam int WIDTH = 25;
    localparam int DEPTH = 8;
    localparam int IDX_W = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    tap_delay_line_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) bus ();

    tap_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] tap(input int k);
        return bus.taps[k*WIDTH +: WIDTH];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift(input logic [WIDTH-1:0] v);
        bus.din      = v;
        bus.shift_en = 1'b1;
        tick();
        bus.shift_en = 1'b0;
    endtask

    task automatic do_clr();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.taps !== '0) begin
            errors++;
            $display("FAIL reset_taps: got %0h expected 0", bus.taps);
        end
        checks++;
        if (bus.fill_cnt !== 4'd0 || bus.full !== 1'b0) begin
            errors++;
            $display("FAIL reset_fill: got cnt=%0d full=%0b expected cnt=0 full=0", bus.fill_cnt, bus.full);
        end
        checks++;
        if (bus.rd_data !== '0) begin
            errors++;
            $display("FAIL reset_rd_data: got %0h expected 0", bus.rd_data);
        end
`ifdef TAP_DELAY_LINE_SUM_EN
        checks++;
        if (bus.sum !== '0) begin
            errors++;
            $display("FAIL reset_sum: got %0h expected 0", bus.sum);
        end
`endif
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            shift(WIDTH'(i));
            if (i == 1) begin
                checks++;
                if (tap(0) !== 25'd1 || bus.fill_cnt !== 4'd1) begin
                    errors++;
                    $display("FAIL fill_first: got tap0=%0d cnt=%0d expected tap0=1 cnt=1", tap(0), bus.fill_cnt);
                end
            end
            if (i == 7) begin
                checks++;
                if (bus.full !== 1'b0 || bus.fill_cnt !== 4'd7) begin
                    errors++;
                    $display("FAIL fill_seven: got cnt=%0d full=%0b expected cnt=7 full=0", bus.fill_cnt, bus.full);
                end
            end
        end
        checks++;
        if (bus.dout !== 25'd1 || bus.full !== 1'b1 || bus.fill_cnt !== 4'd8) begin
            errors++;
            $display("FAIL fill_full: got dout=%0d full=%0b cnt=%0d expected dout=1 full=1 cnt=8",
                     bus.dout, bus.full, bus.fill_cnt);
        end
        shift(25'd9);
        checks++;
        if (bus.dout !== 25'd2 || bus.fill_cnt !== 4'd8 || tap(0) !== 25'd9) begin
            errors++;
            $display("FAIL fill_ninth: got dout=%0d cnt=%0d tap0=%0d expected dout=2 cnt=8 tap0=9",
                     bus.dout, bus.fill_cnt, tap(0));
        end
    endtask

    task automatic test_gap();
        logic [DEPTH*WIDTH-1:0] exp_taps;
        do_clr();
        for (int i = 1; i <= 3; i++) shift(WIDTH'(i));
        exp_taps = '0;
        exp_taps[0*WIDTH +: WIDTH] = 25'd3;
        exp_taps[1*WIDTH +: WIDTH] = 25'd2;
        exp_taps[2*WIDTH +: WIDTH] = 25'd1;
        for (int c = 0; c < 5; c++) begin
            bus.din = 25'h0055AA;
            tick();
            checks++;
            if (bus.taps !== exp_taps || bus.fill_cnt !== 4'd3) begin
                errors++;
                $display("FAIL gap_hold: cycle %0d got taps=%0h cnt=%0d expected taps=%0h cnt=3",
                         c, bus.taps, bus.fill_cnt, exp_taps);
            end
        end
        shift(25'd4);
        checks++;
        if (bus.fill_cnt !== 4'd4 || tap(0) !== 25'd4 || tap(3) !== 25'd1) begin
            errors++;
            $display("FAIL gap_resume: got cnt=%0d tap0=%0d tap3=%0d expected cnt=4 tap0=4 tap3=1",
                     bus.fill_cnt, tap(0), tap(3));
        end
    endtask

    task automatic test_clr_priority();
        for (int i = 1; i <= 8; i++) shift(WIDTH'(i + 20));
        bus.clr      = 1'b1;
        bus.shift_en = 1'b1;
        bus.din      = 25'h1ABCDEF;
        tick();
        bus.clr      = 1'b0;
        bus.shift_en = 1'b0;
        checks++;
        if (bus.taps !== '0 || bus.fill_cnt !== 4'd0 || bus.full !== 1'b0) begin
            errors++;
            $display("FAIL clr_shift: got taps=%0h cnt=%0d full=%0b expected all 0",
                     bus.taps, bus.fill_cnt, bus.full);
        end
        shift(25'd5);
        checks++;
        if (tap(0) !== 25'd5 || tap(1) !== 25'd0 || bus.fill_cnt !== 4'd1) begin
            errors++;
            $display("FAIL clr_after: got tap0=%0h tap1=%0h cnt=%0d expected tap0=5 tap1=0 cnt=1",
                     tap(0), tap(1), bus.fill_cnt);
        end
    endtask

    task automatic test_readback();
        do_clr();
        for (int i = 1; i <= 8; i++) shift(WIDTH'(i));
        bus.rd_idx = 3'd2;
        tick();
        checks++;
        if (bus.rd_data !== 25'd6) begin
            errors++;
            $display("FAIL rd_idx2: got %0d expected 6", bus.rd_data);
        end
        bus.rd_idx = 3'd7;
        tick();
        checks++;
        if (bus.rd_data !== 25'd1) begin
            errors++;
            $display("FAIL rd_idx7: got %0d expected 1", bus.rd_data);
        end
        // rd_data must reflect the pre-edge stage 0 even while it is being overwritten
        bus.rd_idx = 3'd0;
        shift(25'd9);
        checks++;
        if (bus.rd_data !== 25'd8 || tap(0) !== 25'd9) begin
            errors++;
            $display("FAIL rd_pre_edge: got rd=%0d tap0=%0d expected rd=8 tap0=9", bus.rd_data, tap(0));
        end
        tick();
        checks++;
        if (bus.rd_data !== 25'd9) begin
            errors++;
            $display("FAIL rd_follow: got %0d expected 9", bus.rd_data);
        end
    endtask

    task automatic test_async_reset();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.taps !== '0 || bus.fill_cnt !== 4'd0 || bus.full !== 1'b0 || bus.rd_data !== '0) begin
            errors++;
            $display("FAIL async_rst: got taps=%0h cnt=%0d full=%0b rd=%0h expected all 0",
                     bus.taps, bus.fill_cnt, bus.full, bus.rd_data);
        end
        #1;
        rst = 1'b0;
        shift(25'h42);
        checks++;
        if (tap(0) !== 25'h42 || tap(1) !== 25'd0 || bus.fill_cnt !== 4'd1) begin
            errors++;
            $display("FAIL rst_release: got tap0=%0h tap1=%0h cnt=%0d expected tap0=42 tap1=0 cnt=1",
                     tap(0), tap(1), bus.fill_cnt);
        end
    endtask

`ifdef TAP_DELAY_LINE_SUM_EN
    task automatic test_sum();
        logic signed [WIDTH+IDX_W:0] exp_sum [3];
        exp_sum[0] = -29'sd2;
        exp_sum[1] = 29'sd4;
        exp_sum[2] = 29'sd10;
        do_clr();
        for (int i = 0; i < 8; i++) shift(25'h1FFFFFF);
        checks++;
        if (bus.sum !== -29'sd8) begin
            errors++;
            $display("FAIL sum_neg: got %0d expected -8", bus.sum);
        end
        for (int i = 0; i < 3; i++) begin
            shift(25'd5);
            checks++;
            if (bus.sum !== exp_sum[i]) begin
                errors++;
                $display("FAIL sum_step%0d: got %0d expected %0d", i, bus.sum, exp_sum[i]);
            end
        end
        do_clr();
        checks++;
        if (bus.sum !== '0) begin
            errors++;
            $display("FAIL sum_clr: got %0d expected 0", bus.sum);
        end
    endtask
`endif

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.clr      = 1'b0;
        bus.shift_en = 1'b0;
        bus.din      = '0;
        bus.rd_idx   = '0;
        #2;
        test_reset();
        #10;
        rst = 1'b0;
        tick();
        test_fill();
        test_gap();
        test_clr_priority();
        test_readback();
        test_async_reset();
`ifdef TAP_DELAY_LINE_SUM_EN
        test_sum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
